wshb_sdram_arbiter: RTL and testbench

- Round-robin Wishbone arbiter that shares the single SDRAM slave port between N internal masters (default order: 0 = vga, 1 = mire, 2 = stream). Sits in the sys_clk domain between the masters and hw_support's SDRAM slave.
- Registered grant; combinational routing of the granted master to the slave.
- Per-grant ack quantum so the mire or stream cannot starve the VGA refill.

---
 rtl/wshb_sdram_arbiter.sv | 144 ++++++++++++++
 tb/tb_wshb_sdram_arbiter.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wshb_sdram_arbiter.sv
// Round-robin Wishbone arbiter sharing one SDRAM slave port between N masters.
// Registered grant with combinational routing and a per-grant ack quantum.
module wshb_sdram_arbiter #(
    parameter int N       = 3,
    parameter int QUANTUM = 64,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [N-1:0]        m_cyc,
    input  logic [N-1:0]        m_stb,
    input  logic [N-1:0]        m_we,
    input  logic [N*AW-1:0]     m_adr,
    input  logic [N*DW-1:0]     m_dat_ms,
    input  logic [N*DW/8-1:0]   m_sel,
    input  logic [3*N-1:0]      m_cti,
    input  logic [2*N-1:0]      m_bte,
    output logic [N-1:0]        m_ack,
    output logic [N-1:0]        m_err,
    output logic [N-1:0]        m_rty,
    output logic [DW-1:0]       m_dat_sm,
    output logic                s_cyc,
    output logic                s_stb,
    output logic                s_we,
    output logic [AW-1:0]       s_adr,
    output logic [DW-1:0]       s_dat_ms,
    output logic [DW/8-1:0]     s_sel,
    output logic [2:0]          s_cti,
    output logic [1:0]          s_bte,
    input  logic                s_ack,
    input  logic                s_err,
    input  logic                s_rty,
    input  logic [DW-1:0]       s_dat_sm,
    output logic [N-1:0]        grant
);

    localparam int SW = DW / 8;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(QUANTUM + 1);

    typedef enum logic {ARB, OWN} state_t;

    state_t         state, state_nx;
    logic [N-1:0]   grant_nx;
    logic [IW-1:0]  own, own_nx;
    logic [IW-1:0]  last, last_nx;
    logic [IW-1:0]  pick;
    logic [CW-1:0]  cnt, cnt_nx;
    logic           found;
    logic           others;
    logic           bound;
    logic           drop;
    logic [2:0]     own_cti;

    // first requester after the previous owner, wrapping modulo N
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!found && m_cyc[(int'(last) + k) % N]) begin
                pick  = IW'((int'(last) + k) % N);
                found = 1'b1;
            end
        end
    end

    assign own_cti = m_cti[3*own +: 3];
    assign others  = |(m_cyc & ~grant);
    assign bound   = (own_cti == 3'b000) || (own_cti == 3'b111);

    // bursts (cti 010) are never split, even past the quantum
    assign drop = !m_cyc[own]
               || (cnt >= CW'(QUANTUM - 1) && s_ack && others && bound)
               || ((s_err || s_rty) && bound && others);

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        own_nx   = own;
        last_nx  = last;
        cnt_nx   = cnt;
        case (state)
            ARB: begin
                if (found) begin
                    state_nx       = OWN;
                    own_nx         = pick;
                    grant_nx       = '0;
                    grant_nx[pick] = 1'b1;
                    cnt_nx         = '0;
                end
            end
            OWN: begin
                if (s_ack && cnt != CW'(QUANTUM))
                    cnt_nx = cnt + 1'b1;
                if (drop) begin
                    state_nx = ARB;
                    grant_nx = '0;
                    last_nx  = own;
                end
            end
            default: state_nx = ARB;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state <= ARB;
            grant <= '0;
            own   <= '0;
            last  <= IW'(N - 1);
            cnt   <= '0;
        end else begin
            state <= state_nx;
            grant <= grant_nx;
            own   <= own_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = m_we[own];
        s_adr    = m_adr[AW*own +: AW];
        s_dat_ms = m_dat_ms[DW*own +: DW];
        s_sel    = m_sel[SW*own +: SW];
        s_cti    = own_cti;
        s_bte    = m_bte[2*own +: 2];
        m_ack    = '0;
        m_err    = '0;
        m_rty    = '0;
        m_dat_sm = s_dat_sm;
        if (state == OWN) begin
            s_cyc      = m_cyc[own];
            s_stb      = m_stb[own];
            m_ack[own] = s_ack;
            m_err[own] = s_err;
            m_rty[own] = s_rty;
        end
    end

endmodule

// File: tb/tb_wshb_sdram_arbiter.sv
// Bench for wshb_sdram_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin reference model.
module tb_wshb_sdram_arbiter;

    localparam int N  = 3;
    localparam int Q  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    m_cyc, m_stb, m_we, m_ack, m_err, m_rty, grant;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat_ms;
    logic [N*4-1:0]  m_sel;
    logic [3*N-1:0]  m_cti;
    logic [2*N-1:0]  m_bte;
    logic [DW-1:0]   m_dat_sm, s_dat_ms, s_dat_sm;
    logic            s_cyc, s_stb, s_we, s_ack, s_err, s_rty;
    logic [AW-1:0]   s_adr;
    logic [3:0]      s_sel;
    logic [2:0]      s_cti;
    logic [1:0]      s_bte;

    always #5 clk = ~clk;

    wshb_sdram_arbiter #(.N(N), .QUANTUM(Q), .AW(AW), .DW(DW)) dut (
        .sys_clk(clk), .sys_rst_n(rst_n),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_ms(m_dat_ms), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte),
        .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty), .m_dat_sm(m_dat_sm),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti), .s_bte(s_bte),
        .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_dat_sm(s_dat_sm),
        .grant(grant)
    );

    int n_vec = 0;
    int n_bad = 0;

    // reference model: current owner (-1 = arbitrating), last owner, acks this grant
    int own  = -1;
    int last = N - 1;
    int cnt  = 0;
    logic [N-1:0] eg, eack, eerr, erty;
    logic         esc, esb;

    // master agents: beats remaining and burst mode; slave behaviour knobs
    int left[N];
    bit bst[N];
    int slave_mode = 0;
    int err_who    = -1;

    task automatic drive();
        int r;
        for (int i = 0; i < N; i++) begin
            m_cyc[i] = left[i] > 0;
            m_stb[i] = left[i] > 0;
            m_we[i]  = 1'($urandom);
            m_adr[i*AW +: AW]    = $urandom;
            m_dat_ms[i*DW +: DW] = $urandom;
            m_sel[i*4 +: 4]      = 4'($urandom);
            m_bte[i*2 +: 2]      = 2'($urandom);
            m_cti[i*3 +: 3] = !bst[i] ? 3'b000 : (left[i] <= 1 ? 3'b111 : 3'b010);
        end
        s_dat_sm = $urandom;
        s_ack = 1'b0;
        s_err = 1'b0;
        s_rty = 1'b0;
        if (own >= 0 && m_cyc[own]) begin
            if (err_who == own) begin
                s_err   = 1'b1;
                err_who = -1;
            end else if (slave_mode == 0) begin
                s_ack = 1'b1;
            end else begin
                r = $urandom_range(0, 15);
                if (r < 10) s_ack = 1'b1;
                else if (r == 10 && slave_mode == 2) s_err = 1'b1;
                else if (r == 11 && slave_mode == 2) s_rty = 1'b1;
            end
        end
    endtask

    // expected combinational view of the current cycle
    task automatic settle();
        @(negedge clk);
        eg = '0; eack = '0; eerr = '0; erty = '0;
        esc = 1'b0; esb = 1'b0;
        if (own >= 0) begin
            eg[own]   = 1'b1;
            esc       = m_cyc[own];
            esb       = m_stb[own];
            eack[own] = s_ack;
            eerr[own] = s_err;
            erty[own] = s_rty;
        end
    endtask

    task automatic advance();
        logic [N-1:0] others_m;
        logic [2:0]   c;
        bit           bnd, rel;
        @(posedge clk);
        if (!rst_n) begin
            own = -1; last = N - 1; cnt = 0;
        end else if (own < 0) begin
            for (int k = 1; k <= N; k++)
                if (own < 0 && m_cyc[(last + k) % N]) begin
                    own = (last + k) % N;
                    cnt = 0;
                end
        end else begin
            others_m = m_cyc;
            others_m[own] = 1'b0;
            c   = m_cti[own*3 +: 3];
            bnd = (c == 3'b000) || (c == 3'b111);
            rel = !m_cyc[own]
               || (cnt >= Q - 1 && s_ack && |others_m && bnd)
               || ((s_err || s_rty) && bnd && |others_m);
            if (s_ack && cnt < Q) cnt++;
            if (rel) begin
                last = own;
                own  = -1;
            end
        end
        for (int i = 0; i < N; i++)
            if (eack[i] || eerr[i] || erty[i]) left[i]--;
        #1;
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            left[i] = 0;
            bst[i]  = 1'b0;
        end
        err_who    = -1;
        slave_mode = 0;
        drive();
        settle(); advance();
        settle(); advance();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        n_vec++;
        if (grant !== 3'b000 || grant !== eg) begin
            n_bad++; $display("FAIL reset_grant: got %b want 000", grant);
        end
        n_vec++;
        if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin
            n_bad++; $display("FAIL reset_scyc: got %b%b want 00", s_cyc, s_stb);
        end
        n_vec++;
        if ({m_ack, m_err, m_rty} !== 9'b0) begin
            n_bad++; $display("FAIL reset_resp: got %b want 0", {m_ack, m_err, m_rty});
        end
        advance();
    endtask

    task automatic test_single();
        int acks;
        acks = 0;
        do_reset();
        left[0] = 6;
        drive();
        settle();
        n_vec++;
        if (s_cyc !== 1'b0) begin
            n_bad++; $display("FAIL single_lat0: s_cyc got %b want 0", s_cyc);
        end
        advance();
        settle();
        n_vec++;
        if (s_cyc !== 1'b1 || grant !== 3'b001) begin
            n_bad++; $display("FAIL single_lat1: s_cyc/grant got %b/%b want 1/001", s_cyc, grant);
        end
        for (int t = 0; t < 12; t++) begin
            if (t > 0) settle();
            n_vec++;
            if (m_ack !== eack || m_ack[2:1] !== 2'b00) begin
                n_bad++; $display("FAIL single_ack: got %b want %b", m_ack, eack);
            end
            n_vec++;
            if (s_cyc && s_adr !== m_adr[AW-1:0]) begin
                n_bad++; $display("FAIL single_adr: got %h want %h", s_adr, m_adr[AW-1:0]);
            end
            if (m_ack[0]) acks++;
            advance();
        end
        n_vec++;
        if (acks != 6) begin
            n_bad++; $display("FAIL single_count: got %0d acks want 6", acks);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] seq[$];
        int gaps[$];
        logic [N-1:0] prev;
        int gap;
        prev = '0;
        gap  = 0;
        do_reset();
        for (int i = 0; i < N; i++) left[i] = 2;
        drive();
        for (int t = 0; t < 40; t++) begin
            settle();
            n_vec++;
            if (grant !== eg) begin
                n_bad++; $display("FAIL rr_grant: got %b want %b", grant, eg);
            end
            if (grant == '0) begin
                gap++;
                n_vec++;
                if (s_cyc !== 1'b0) begin
                    n_bad++; $display("FAIL rr_idle: s_cyc got %b want 0", s_cyc);
                end
            end else begin
                if (grant != prev) begin
                    if (prev != '0) gaps.push_back(gap);
                    seq.push_back(grant);
                    prev = grant;
                end
                gap = 0;
            end
            advance();
        end
        n_vec++;
        if (seq.size() != 3 || seq[0] != 3'b001 || seq[1] != 3'b010 || seq[2] != 3'b100) begin
            n_bad++; $display("FAIL rr_order: got %0d grants want 001,010,100", seq.size());
        end
        n_vec++;
        if (gaps.size() != 2 || gaps[0] != 1 || gaps[1] != 1) begin
            n_bad++; $display("FAIL rr_gap: got %0d gaps want two of 1 cycle", gaps.size());
        end
    endtask

    task automatic test_quantum();
        int a1, idle, hold;
        bit seen0, regr;
        a1 = 0; idle = 0; hold = 0; seen0 = 0; regr = 0;
        do_reset();
        left[1] = 1000;
        drive();
        for (int t = 0; t < 60; t++) begin
            settle();
            n_vec++;
            if (grant !== eg) begin
                n_bad++; $display("FAIL q_grant: got %b want %b", grant, eg);
            end
            if (!seen0) begin
                if (m_ack[1]) a1++;
                if (grant == '0 && a1 > 0) idle++;
                if (grant == 3'b001) seen0 = 1;
            end else if (!regr) begin
                if (grant == 3'b010) regr = 1;
            end else begin
                hold++;
                n_vec++;
                if (grant !== 3'b010) begin
                    n_bad++; $display("FAIL q_hold: got %b want 010", grant);
                end
            end
            advance();
            if (t == 1) begin
                left[0] = 3;
                drive();
            end
        end
        n_vec++;
        if (a1 != 4) begin
            n_bad++; $display("FAIL q_acks: got %0d want 4", a1);
        end
        n_vec++;
        if (idle != 1 || !regr || hold < 20) begin
            n_bad++; $display("FAIL q_handover: idle %0d regrant %0d hold %0d want 1 1 >=20", idle, regr, hold);
        end
    endtask

    task automatic test_burst();
        int a2, t_end, t0;
        bit seen0;
        a2 = 0; t_end = -100; t0 = -1; seen0 = 0;
        do_reset();
        slave_mode = 1;
        left[2] = 16;
        bst[2]  = 1'b1;
        drive();
        settle(); advance();
        left[0] = 2;
        drive();
        for (int t = 0; t < 80; t++) begin
            settle();
            n_vec++;
            if (grant !== eg || m_ack !== eack) begin
                n_bad++; $display("FAIL burst_route: grant %b ack %b want %b %b", grant, m_ack, eg, eack);
            end
            if (!seen0) begin
                if (m_ack[2]) a2++;
                if (m_ack[2] && m_cti[8:6] == 3'b111) t_end = t;
                if (grant == 3'b001) begin
                    seen0 = 1;
                    t0 = t;
                end
            end
            advance();
        end
        n_vec++;
        if (a2 != 16) begin
            n_bad++; $display("FAIL burst_acks: got %0d want 16", a2);
        end
        n_vec++;
        if (t0 - t_end != 2) begin
            n_bad++; $display("FAIL burst_lat: got %0d cycles want 2", t0 - t_end);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        left[0] = 20;
        bst[0]  = 1'b1;
        drive();
        repeat (5) begin
            settle(); advance();
        end
        left[1] = 3;
        drive();
        settle();
        rst_n = 1'b0;
        advance();
        rst_n = 1'b1;
        settle();
        n_vec++;
        if (grant !== 3'b000 || s_cyc !== 1'b0 || m_ack !== 3'b000) begin
            n_bad++; $display("FAIL rstmid_drop: grant %b s_cyc %b ack %b want 000 0 000", grant, s_cyc, m_ack);
        end
        advance();
        settle();
        n_vec++;
        if (grant !== 3'b001 || grant !== eg) begin
            n_bad++; $display("FAIL rstmid_regrant: got %b want 001", grant);
        end
        advance();
        left[0] = 1;
        drive();
        for (int t = 0; t < 20; t++) begin
            settle();
            n_vec++;
            if (grant !== eg || m_ack !== eack) begin
                n_bad++; $display("FAIL rstmid_tail: grant %b ack %b want %b %b", grant, m_ack, eg, eack);
            end
            advance();
        end
    endtask

    task automatic test_err();
        int te, tg;
        te = -1; tg = -1;
        do_reset();
        err_who = 1;
        left[1] = 3;
        left[2] = 2;
        drive();
        for (int t = 0; t < 30; t++) begin
            settle();
            n_vec++;
            if (grant !== eg || m_err !== eerr) begin
                n_bad++; $display("FAIL err_route: grant %b err %b want %b %b", grant, m_err, eg, eerr);
            end
            if (m_err[1] && te < 0) begin
                te = t;
                n_vec++;
                if (m_err !== 3'b010 || m_ack !== 3'b000) begin
                    n_bad++; $display("FAIL err_pulse: err %b ack %b want 010 000", m_err, m_ack);
                end
            end
            if (te >= 0 && t == te + 1) begin
                n_vec++;
                if (m_err !== 3'b000 || grant !== 3'b000) begin
                    n_bad++; $display("FAIL err_after: err %b grant %b want 000 000", m_err, grant);
                end
            end
            if (grant == 3'b100 && tg < 0) tg = t;
            advance();
        end
        n_vec++;
        if (te < 0 || tg - te != 2) begin
            n_bad++; $display("FAIL err_handover: err at %0d grant100 at %0d want gap 2", te, tg);
        end
    endtask

    task automatic test_random();
        do_reset();
        slave_mode = 2;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++)
                if (left[i] <= 0 && $urandom_range(0, 5) == 0) begin
                    left[i] = $urandom_range(1, 12);
                    bst[i]  = 1'($urandom);
                end
            rst_n = ($urandom_range(0, 399) != 0);
            drive();
            settle();
            n_vec++;
            if (grant !== eg || !$onehot0(grant)) begin
                n_bad++; $display("FAIL rnd_grant: got %b want %b", grant, eg);
            end
            n_vec++;
            if ({s_cyc, s_stb} !== {esc, esb}) begin
                n_bad++; $display("FAIL rnd_ctl: got %b%b want %b%b", s_cyc, s_stb, esc, esb);
            end
            n_vec++;
            if ({m_ack, m_err, m_rty} !== {eack, eerr, erty}) begin
                n_bad++; $display("FAIL rnd_resp: got %b want %b", {m_ack, m_err, m_rty}, {eack, eerr, erty});
            end
            n_vec++;
            if (m_dat_sm !== s_dat_sm) begin
                n_bad++; $display("FAIL rnd_rdata: got %h want %h", m_dat_sm, s_dat_sm);
            end
            if (own >= 0) begin
                n_vec++;
                if ({s_adr, s_dat_ms, s_sel, s_cti, s_bte, s_we} !==
                    {m_adr[own*AW +: AW], m_dat_ms[own*DW +: DW], m_sel[own*4 +: 4],
                     m_cti[own*3 +: 3], m_bte[own*2 +: 2], m_we[own]}) begin
                    n_bad++; $display("FAIL rnd_mux: owner %0d adr %h want %h", own, s_adr, m_adr[own*AW +: AW]);
                end
            end
            advance();
            rst_n = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            left[i] = 0;
            bst[i]  = 1'b0;
        end
        drive();
        test_reset();
        test_single();
        test_round_robin();
        test_quantum();
        test_burst();
        test_reset_mid();
        test_err();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
